data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Responder side of the processor data-memory interface (memread/memwrite/data_address/writedata -> received_data).
//  Decodes each access to either a word-addressed data RAM or a small memory-mapped I/O block (GPIO, timer, status).
//  Sits outside the processor top and returns read data in the same cycle; the MEM/WB pipeline register captures it.
// PARAMETERS
//  MEMORY_DEPTH  64            number of 32-bit RAM words; power of two, >= 4
//  RAM_BASE      32'h10010000  RAM base address; must be aligned to 4*MEMORY_DEPTH
//  IO_BASE       32'h10020000  I/O register block base address; 32-byte aligned
//  GPIO_WIDTH    8             width of gpio_in / gpio_out, 1..32
// PORTS
//  clk            input   1           system clock, rising edge
//  reset          input   1           asynchronous, active-low reset
//  memread        input   1           read strobe for the current cycle
//  memwrite       input   1           write strobe for the current cycle
//  data_address   input   32          byte address; bits [1:0] are ignored (word accesses only)
//  writedata      input   32          write data
//  received_data  output  32          read data, combinational from address/state
//  gpio_in        input   GPIO_WIDTH  asynchronous external inputs
//  gpio_out       output  GPIO_WIDTH  GPIO output register
//  timer_irq      output  1           equals STATUS[0]
//  bus_error      output  1           equals STATUS[1]
// BEHAVIOUR
//  Decode:
//   - RAM hit: (data_address - RAM_BASE) < 4*MEMORY_DEPTH.
//     Index = (data_address - RAM_BASE) >> 2, clog2(MEMORY_DEPTH) bits.
//   - IO hit: data_address[31:5] == IO_BASE[31:5] and offset <= 0x10. Anything else is unmapped.
//  IO map (offset from IO_BASE):
//   - 0x00 GPIO_OUT: RW.
//   - 0x04 GPIO_IN: RO; synchronized input, zero-extended.
//   - 0x08 TIMER_COUNT: RW.
//   - 0x0C TIMER_CMP: RW.
//   - 0x10 STATUS: [0] timer match and [1] bus error, both sticky. Writing 1 clears a bit; writing 0 has no effect.
//     Bits [31:2] read 0.
//  Reads:
//   - Combinational, zero latency.
//   - received_data = 0 when memread=0 or the access is unmapped.
//  Writes:
//   - Committed on the rising clk edge when memwrite=1. Writes to RO or unmapped addresses change no data.
//  memread & memwrite together:
//   - The write commits at the edge.
//   - received_data in that cycle shows the pre-write value (read-before-write).
//  Bus error:
//   - STATUS[1] is set at the edge of any cycle with (memread|memwrite)=1 and an unmapped address.
//  Timer:
//   - TIMER_COUNT increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0.
//   - A CPU write to TIMER_COUNT takes priority over the increment and loads writedata.
//   - STATUS[0] is set at an edge when the pre-edge TIMER_COUNT == TIMER_CMP.
//  Simultaneous events:
//   - If a STATUS bit is being set and cleared by W1C at the same edge, the set wins.
//  GPIO_IN path:
//   - gpio_in passes through a 2-flop synchronizer.
//   - A change is readable 2 edges later; no combinational path from gpio_in to received_data.
//  Reset (reset=0, asynchronous):
//   - GPIO_OUT = 0, TIMER_COUNT = 0, TIMER_CMP = 32'hFFFFFFFF, STATUS = 0, synchronizer flops = 0.
//   - gpio_out = 0, timer_irq = 0, bus_error = 0.
//   - RAM contents are NOT reset and remain defined across reset.
//  Reset asserted mid-access: any in-flight write is dropped; registers take reset values immediately.
//  Release is synchronous-safe: the first write commits at the first rising edge with reset=1.
// TESTING
//  1. RAM write 0xDEADBEEF to 0x10010008, then read 0x10010008 -> received_data = 0xDEADBEEF; read 0x1001000B -> same word.
//  2. Read-before-write: RAM[1] = 5; one cycle with memread=memwrite=1 at 0x10010004, writedata=9
//     -> that cycle reads 5; next read gives 9.
//  3. Write 0x0A5 to IO 0x10020000 -> gpio_out = 0xA5 after the edge.
//     gpio_in 0x00 -> 0x3C: IO 0x04 reads 0 for 1 edge, then 0x3C after the 2nd edge.
//  4. Write CMP = 10, then COUNT = 0 -> timer_irq rises at the 11th edge after the COUNT write.
//     W1C write 1 to 0x10020010 in the same cycle as a match -> bit stays 1.
//  5. memread at 0x20000000 -> received_data = 0, bus_error = 1 after the edge.
//     memread=memwrite=0 at the same address -> no set.
//     Write 2 to STATUS -> bus_error = 0.
//  6. Assert reset mid-run with gpio_out = 0xFF and timer running -> all outputs 0, COUNT = 0 asynchronously.
//     RAM word written earlier still reads back.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: responder for the processor data-memory port.
// Decodes each word access to a word-addressed RAM or to a small I/O block
// (GPIO out/in, free-running timer with compare, sticky W1C status) and
// returns read data combinationally in the same cycle.
module data_memory_responder #(
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] RAM_BASE     = 32'h10010000,
  parameter logic [31:0] IO_BASE      = 32'h10020000,
  parameter int          GPIO_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [31:0]           data_address,
  input  logic [31:0]           writedata,
  output logic [31:0]           received_data,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq,
  output logic                  bus_error
);

  localparam int          AW        = $clog2(MEMORY_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEMORY_DEPTH);

  // Word offsets inside the I/O block
  localparam logic [2:0] IO_GPIO_OUT = 3'd0;
  localparam logic [2:0] IO_GPIO_IN  = 3'd1;
  localparam logic [2:0] IO_COUNT    = 3'd2;
  localparam logic [2:0] IO_CMP      = 3'd3;
  localparam logic [2:0] IO_STATUS   = 3'd4;

  logic [31:0] mem [MEMORY_DEPTH];

  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_WIDTH-1:0] gpio_sync1_q, gpio_sync1_d;
  logic [GPIO_WIDTH-1:0] gpio_sync2_q, gpio_sync2_d;
  logic [31:0]           timer_count_q, timer_count_d;
  logic [31:0]           timer_cmp_q, timer_cmp_d;
  logic [1:0]            status_q, status_d;

  logic [31:0]   ram_off;
  logic [AW-1:0] ram_idx;
  logic [2:0]    io_word;
  logic          ram_hit, io_hit, unmapped;
  logic          ram_we, io_we;
  logic          timer_match, bus_err_set;
  logic [31:0]   rd_word;
  logic [31:0]   gpio_out_ext, gpio_in_ext;

  // Address decode; RAM wins if a misconfiguration ever overlaps the two windows
  always_comb begin
    ram_off     = data_address - RAM_BASE;
    ram_hit     = (ram_off < RAM_BYTES);
    ram_idx     = ram_off[AW+1:2];
    io_word     = data_address[4:2];
    io_hit      = !ram_hit && (data_address[31:5] == IO_BASE[31:5]) && (io_word <= IO_STATUS);
    unmapped    = !ram_hit && !io_hit;
    // A write seen while reset is held must not reach the RAM either
    ram_we      = memwrite && ram_hit && reset;
    io_we       = memwrite && io_hit;
    timer_match = (timer_count_q == timer_cmp_q);
    bus_err_set = (memread || memwrite) && unmapped;
  end

  // Zero-extend the GPIO registers to bus width
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_ext
      if (gi < GPIO_WIDTH) begin : g_bit
        assign gpio_out_ext[gi] = gpio_out_q[gi];
        assign gpio_in_ext[gi]  = gpio_sync2_q[gi];
      end else begin : g_zero
        assign gpio_out_ext[gi] = 1'b0;
        assign gpio_in_ext[gi]  = 1'b0;
      end
    end
  endgenerate

  // Read mux: pre-edge state, so a simultaneous write shows the old value
  always_comb begin
    rd_word = '0;
    if (ram_hit) begin
      rd_word = mem[ram_idx];
    end else if (io_hit) begin
      case (io_word)
        IO_GPIO_OUT: rd_word = gpio_out_ext;
        IO_GPIO_IN:  rd_word = gpio_in_ext;
        IO_COUNT:    rd_word = timer_count_q;
        IO_CMP:      rd_word = timer_cmp_q;
        IO_STATUS:   rd_word = {30'd0, status_q};
        default:     rd_word = '0;
      endcase
    end
    received_data = memread ? rd_word : '0;
  end

  // Next-state for I/O registers, timer and synchronizer
  always_comb begin
    gpio_out_d    = gpio_out_q;
    timer_cmp_d   = timer_cmp_q;
    timer_count_d = timer_count_q + 32'd1;
    gpio_sync1_d  = gpio_in;
    gpio_sync2_d  = gpio_sync1_q;
    status_d      = status_q;
    if (io_we) begin
      case (io_word)
        IO_GPIO_OUT: gpio_out_d    = writedata[GPIO_WIDTH-1:0];
        IO_COUNT:    timer_count_d = writedata;
        IO_CMP:      timer_cmp_d   = writedata;
        IO_STATUS:   status_d      = status_q & ~writedata[1:0];
        default:     ;
      endcase
    end
    // Setting events override a same-edge W1C clear
    status_d = status_d | {bus_err_set, timer_match};
  end

  // Register state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_q    <= '0;
      gpio_sync1_q  <= '0;
      gpio_sync2_q  <= '0;
      timer_count_q <= '0;
      timer_cmp_q   <= 32'hFFFF_FFFF;
      status_q      <= '0;
    end else begin
      gpio_out_q    <= gpio_out_d;
      gpio_sync1_q  <= gpio_sync1_d;
      gpio_sync2_q  <= gpio_sync2_d;
      timer_count_q <= timer_count_d;
      timer_cmp_q   <= timer_cmp_d;
      status_q      <= status_d;
    end
  end

  // Data RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= writedata;
    end
  end

  assign gpio_out  = gpio_out_q;
  assign timer_irq = status_q[0];
  assign bus_error = status_q[1];

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios plus a
// randomized run against a behavioural model of the memory map.
module tb_data_memory_responder;

  localparam logic [31:0] RAM_BASE = 32'h10010000;
  localparam logic [31:0] IO_BASE  = 32'h10020000;
  localparam int          DEPTH    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] received_data;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_memory_responder #(
    .MEMORY_DEPTH(DEPTH), .RAM_BASE(RAM_BASE), .IO_BASE(IO_BASE), .GPIO_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .data_address(data_address), .writedata(writedata), .received_data(received_data),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq), .bus_error(bus_error)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] ram_m [DEPTH];
  logic [7:0]  gpio_out_m;
  logic [7:0]  gin_s1, gin_s2;
  logic [31:0] cmp_m, count_base;
  longint      cyc, load_cyc;
  logic [1:0]  status_m;

  // Timer value = last loaded value plus edges elapsed since the load
  function logic [31:0] count_now();
    return count_base + 32'(cyc - load_cyc);
  endfunction

  // 0 = RAM, 1 = I/O, 2 = unmapped
  function int region(input logic [31:0] a);
    if (a >= RAM_BASE && a < RAM_BASE + 32'(4 * DEPTH)) return 0;
    if (a >= IO_BASE && a < IO_BASE + 32'h14) return 1;
    return 2;
  endfunction

  function logic [31:0] model_read(input logic [31:0] a);
    int r;
    r = region(a);
    if (r == 0) return ram_m[(a - RAM_BASE) >> 2];
    if (r == 1) begin
      case ((a - IO_BASE) >> 2)
        0: return {24'd0, gpio_out_m};
        1: return {24'd0, gin_s2};
        2: return count_now();
        3: return cmp_m;
        4: return {30'd0, status_m};
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  function void model_reset();
    gpio_out_m = '0;
    gin_s1 = '0;
    gin_s2 = '0;
    cmp_m = 32'hFFFF_FFFF;
    count_base = '0;
    load_cyc = cyc;
    status_m = '0;
  endfunction

  // Apply one rising edge with the bus values currently driven
  function void model_update();
    logic        match, berr;
    int          r;
    logic [31:0] off;
    if (!reset) begin
      cyc++;
      model_reset();
      return;
    end
    match = (count_now() == cmp_m);
    berr  = (memread || memwrite) && (region(data_address) == 2);
    r     = region(data_address);
    cyc++;
    if (memwrite && r == 0) ram_m[(data_address - RAM_BASE) >> 2] = writedata;
    if (memwrite && r == 1) begin
      off = (data_address - IO_BASE) >> 2;
      case (off)
        0: gpio_out_m = writedata[7:0];
        2: begin count_base = writedata; load_cyc = cyc; end
        3: cmp_m = writedata;
        4: status_m = status_m & ~writedata[1:0];
        default: ;
      endcase
    end
    status_m = status_m | {berr, match};
    gin_s2 = gin_s1;
    gin_s1 = gpio_in;
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic set_bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memread = rd;
    memwrite = wr;
    data_address = a;
    writedata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    set_bus(1'b0, 1'b1, a, d);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cyc = 0;
    model_reset();
    repeat (3) tick();
    set_bus(1'b1, 1'b0, IO_BASE + 32'h8, 32'h0);
    reset = 1'b1;
    #1;
    n_tests++;
    if (received_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_count: got %h expected %h", received_data, 32'h0);
    end
    n_tests++;
    if ({gpio_out, timer_irq, bus_error} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", {gpio_out, timer_irq, bus_error}, 10'd0);
    end
    tick();
    set_bus(1'b1, 1'b0, IO_BASE + 32'hC, 32'h0);
    #1;
    n_tests++;
    if (received_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL reset_cmp: got %h expected %h", received_data, 32'hFFFF_FFFF);
    end
    tick();
    set_bus(1'b1, 1'b0, IO_BASE + 32'h10, 32'h0);
    #1;
    n_tests++;
    if (received_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_status: got %h expected %h", received_data, 32'h0);
    end
    tick();
  endtask

  task automatic test_ram();
    do_write(RAM_BASE + 32'h8, 32'hDEAD_BEEF);
    set_bus(1'b1, 1'b0, RAM_BASE + 32'h8, 32'h0);
    #1;
    n_tests++;
    if (received_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ram_read: got %h expected %h", received_data, 32'hDEAD_BEEF);
    end
    tick();
    set_bus(1'b1, 1'b0, RAM_BASE + 32'hB, 32'h0);
    #1;
    n_tests++;
    if (received_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ram_read_lowbits: got %h expected %h", received_data, 32'hDEAD_BEEF);
    end
    tick();
    do_write(RAM_BASE + 32'h4, 32'd5);
    set_bus(1'b1, 1'b1, RAM_BASE + 32'h4, 32'd9);
    #1;
    n_tests++;
    if (received_data !== 32'd5) begin
      n_fail++; $display("FAIL ram_read_before_write: got %h expected %h", received_data, 32'd5);
    end
    tick();
    set_bus(1'b1, 1'b0, RAM_BASE + 32'h4, 32'h0);
    #1;
    n_tests++;
    if (received_data !== 32'd9) begin
      n_fail++; $display("FAIL ram_after_rw: got %h expected %h", received_data, 32'd9);
    end
    tick();
  endtask

  task automatic test_gpio();
    do_write(IO_BASE, 32'h0A5);
    n_tests++;
    if (gpio_out !== 8'hA5) begin
      n_fail++; $display("FAIL gpio_out: got %h expected %h", gpio_out, 8'hA5);
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    gpio_in = 8'h00;
    tick();
    tick();
    set_bus(1'b1, 1'b0, IO_BASE + 32'h4, 32'h0);
    gpio_in = 8'h3C;
    #1;
    n_tests++;
    if (received_data !== 32'h0) begin
      n_fail++; $display("FAIL gpio_in_edge0: got %h expected %h", received_data, 32'h0);
    end
    tick();
    n_tests++;
    if (received_data !== 32'h0) begin
      n_fail++; $display("FAIL gpio_in_edge1: got %h expected %h", received_data, 32'h0);
    end
    tick();
    n_tests++;
    if (received_data !== 32'h3C) begin
      n_fail++; $display("FAIL gpio_in_edge2: got %h expected %h", received_data, 32'h3C);
    end
  endtask

  task automatic test_timer();
    do_write(IO_BASE + 32'h8, 32'd1000);
    do_write(IO_BASE + 32'hC, 32'd10);
    do_write(IO_BASE + 32'h8, 32'd0);
    set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) tick();
      n_tests++;
      if (timer_irq !== (k > 11 - 1 ? 1'b0 : 1'b0) && k < 11) begin
        n_fail++; $display("FAIL timer_early k=%0d: got %b expected %b", k - 1, timer_irq, 1'b0);
      end
    end
    tick();
    n_tests++;
    if (timer_irq !== 1'b1) begin
      n_fail++; $display("FAIL timer_match_edge11: got %b expected %b", timer_irq, 1'b1);
    end
    // Clear, reload, then collide the W1C with the next match
    do_write(IO_BASE + 32'h8, 32'd0);
    do_write(IO_BASE + 32'h10, 32'd1);
    n_tests++;
    if (timer_irq !== 1'b0) begin
      n_fail++; $display("FAIL timer_w1c: got %b expected %b", timer_irq, 1'b0);
    end
    for (int k = 2; k <= 10; k++) begin
      set_bus(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end
    n_tests++;
    if (timer_irq !== 1'b0) begin
      n_fail++; $display("FAIL timer_before_collide: got %b expected %b", timer_irq, 1'b0);
    end
    do_write(IO_BASE + 32'h10, 32'd1);
    n_tests++;
    if (timer_irq !== 1'b1) begin
      n_fail++; $display("FAIL timer_set_beats_clear: got %b expected %b", timer_irq, 1'b1);
    end
  endtask

  task automatic test_bus_error();
    set_bus(1'b1, 1'b0, 32'h2000_0000, 32'h0);
    #1;
    n_tests++;
    if (received_data !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read: got %h expected %h", received_data, 32'h0);
    end
    tick();
    n_tests++;
    if (bus_error !== 1'b1) begin
      n_fail++; $display("FAIL bus_error_set: got %b expected %b", bus_error, 1'b1);
    end
    do_write(IO_BASE + 32'h10, 32'd2);
    n_tests++;
    if ({bus_error, timer_irq} !== 2'b01) begin
      n_fail++; $display("FAIL bus_error_clear: got %b expected %b", {bus_error, timer_irq}, 2'b01);
    end
    set_bus(1'b0, 1'b0, 32'h2000_0000, 32'h0);
    tick();
    n_tests++;
    if (bus_error !== 1'b0) begin
      n_fail++; $display("FAIL bus_error_idle: got %b expected %b", bus_error, 1'b0);
    end
    do_write(IO_BASE + 32'h14, 32'h1234);
    n_tests++;
    if (bus_error !== 1'b1) begin
      n_fail++; $display("FAIL bus_error_write: got %b expected %b", bus_error, 1'b1);
    end
    do_write(IO_BASE + 32'h10, 32'd2);
  endtask

  task automatic test_random();
    logic        rd, wr;
    logic [31:0] a, d, exp;
    int          cat;
    for (int i = 0; i < DEPTH; i++) do_write(RAM_BASE + 32'(4 * i), $urandom);
    for (int i = 0; i < 400; i++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 2) == 0);
      cat = $urandom_range(0, 9);
      if (cat < 5)       a = RAM_BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (cat < 8)  a = IO_BASE + 32'(4 * $urandom_range(0, 4));
      else if (cat == 8) a = IO_BASE + 32'(4 * $urandom_range(5, 7));
      else               a = $urandom;
      a[1:0] = 2'($urandom);
      d = $urandom;
      if (a[31:2] == IO_BASE[31:2] + 30'd2 && $urandom_range(0, 1) == 1) d = cmp_m - 32'd2;
      set_bus(rd, wr, a, d);
      gpio_in = 8'($urandom);
      #1;
      exp = rd ? model_read(a) : 32'h0;
      n_tests++;
      if (received_data !== exp) begin
        n_fail++; $display("FAIL rand_read #%0d addr=%h: got %h expected %h", i, a, received_data, exp);
      end
      tick();
      n_tests++;
      if ({gpio_out, timer_irq, bus_error} !== {gpio_out_m, status_m[0], status_m[1]}) begin
        n_fail++; $display("FAIL rand_outputs #%0d: got %h expected %h", i,
                           {gpio_out, timer_irq, bus_error}, {gpio_out_m, status_m[0], status_m[1]});
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] kept;
    do_write(IO_BASE, 32'hFF);
    n_tests++;
    if (gpio_out !== 8'hFF) begin
      n_fail++; $display("FAIL midrun_gpio_pre: got %h expected %h", gpio_out, 8'hFF);
    end
    do_write(RAM_BASE + 32'h20, 32'hCAFE_F00D);
    kept = 32'hCAFE_F00D;
    set_bus(1'b0, 1'b1, RAM_BASE + 32'h20, 32'h0BAD_BEEF);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({gpio_out, timer_irq, bus_error} !== 10'd0) begin
      n_fail++; $display("FAIL midrun_outputs: got %h expected %h", {gpio_out, timer_irq, bus_error}, 10'd0);
    end
    memread = 1'b1; memwrite = 1'b0; data_address = IO_BASE + 32'h8;
    #1;
    n_tests++;
    if (received_data !== 32'h0) begin
      n_fail++; $display("FAIL midrun_count: got %h expected %h", received_data, 32'h0);
    end
    memread = 1'b0; memwrite = 1'b1; data_address = RAM_BASE + 32'h20;
    tick();
    set_bus(1'b1, 1'b0, RAM_BASE + 32'h20, 32'h0);
    reset = 1'b1;
    #1;
    n_tests++;
    if (received_data !== kept) begin
      n_fail++; $display("FAIL midrun_ram_kept: got %h expected %h", received_data, kept);
    end
    tick();
    do_write(RAM_BASE + 32'h24, 32'h5A5A_0001);
    set_bus(1'b1, 1'b0, RAM_BASE + 32'h24, 32'h0);
    #1;
    n_tests++;
    if (received_data !== 32'h5A5A_0001) begin
      n_fail++; $display("FAIL post_release_write: got %h expected %h", received_data, 32'h5A5A_0001);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_bus_error();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
